acc16_stage: RTL and testbench
==============================

ACC16_STAGE -- requirements
Module: acc16_stage

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8, which sets the number of adder results per accumulation frame; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port sum_in, input, 16 bits: sum output of the upstream 16-bit ripple-carry adder.
REQ-005 SHALL have port cout_in, input, 1 bit: carry-out of the upstream adder; the beat value is {cout_in,sum_in} (17 bits, unsigned).
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream beat is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle; combinational.
REQ-008 SHALL have port clear, input, 1 bit: synchronous frame abort/restart.
REQ-009 SHALL have port out_valid, output, 1 bit: frame result available; registered.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-011 SHALL have port acc_out, output, 24 bits: accumulated frame total, modulo 2^24; registered.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set if the frame total reached or exceeded 2^24.
REQ-013 SHALL have port count, output, 8 bits: beats accepted in the current frame.

Function
REQ-014 SHALL implement a two-state FSM with states ACCUM and HOLD.
REQ-015 In ACCUM: in_ready = ~clear; in HOLD: in_ready = 0.
REQ-016 Transfer SHALL occur when in_valid & in_ready at a rising edge; no transfer occurs otherwise, so input bubbles are ignored.
REQ-017 On transfer: acc <= (acc + zero-extended beat)[23:0]; ovf <= ovf | carry out of bit 23; count <= count+1.
REQ-018 A transfer with count == N_SAMPLES-1 SHALL move the FSM to HOLD; out_valid SHALL be 1 in the next cycle, i.e. latency is 1 cycle from the final beat.
REQ-019 In HOLD: out_valid = 1; acc_out, ovf and count (= N_SAMPLES) SHALL hold stable until handshake.
REQ-020 In HOLD with out_ready = 1 at an edge: next state ACCUM, acc = 0, count = 0, ovf = 0, out_valid = 0.
REQ-021 No input beat SHALL be accepted in the HOLD-to-ACCUM handoff cycle; the first beat of the next frame is accepted at the earliest 1 cycle after the consume edge.
REQ-022 out_ready SHALL be ignored in ACCUM.
REQ-023 clear = 1 at an edge, in any state: next state ACCUM, acc = 0, count = 0, ovf = 0, out_valid = 0.
REQ-024 clear SHALL take priority over both transfer and consume; a beat presented with clear is not consumed because in_ready = 0.
REQ-025 acc_out SHALL show the running total during ACCUM.

Reset
REQ-026 rst_n = 0 SHALL immediately, without a clock, force state ACCUM, acc_out = 0, ovf = 0, count = 0, out_valid = 0.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result.
REQ-028 Operation SHALL resume at the first rising edge after rst_n deasserts.

Verification
REQ-029 Bench SHALL cover basic frame: N_SAMPLES=4; beats {0,000F},{0,0010},{0,0005},{1,0000}; out_ready=1 -> out_valid for 1 cycle after the 4th beat; acc_out = 0x010024, count = 4, ovf = 0.
REQ-030 Bench SHALL cover overflow: N_SAMPLES=255; every beat {1,FFFF} -> acc_out = 0xFDFF01, ovf = 1, count = 255.
REQ-031 Bench SHALL cover backpressure: N_SAMPLES=4 frame done; out_ready held low 5 cycles -> out_valid = 1, acc_out stable, in_ready = 0 throughout; consumed on first out_ready = 1 edge; next frame accumulates from 0.
REQ-032 Bench SHALL cover bubbles: in_valid alternating 1/0 over the REQ-029 beats -> same result 0x010024, with out_valid 1 cycle after the last accepted beat.
REQ-033 Bench SHALL cover clear collision: clear = 1 with in_valid = 1 after 2 beats -> in_ready = 0 that cycle; next cycle count = 0, acc_out = 0; that beat is not counted.
REQ-034 Bench SHALL cover async reset: rst_n pulsed low between clock edges in HOLD -> out_valid, acc_out, count, ovf = 0 immediately, before the next edge.

Source files
------------

// File: rtl/acc16_stage.sv
// Accumulates N_SAMPLES 17-bit adder beats into a 24-bit total with a sticky overflow flag.
// Result is registered 1 cycle after the final beat and held, with input stalled, until consumed.
module acc16_stage #(
  parameter int N_SAMPLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sum_in,
  input  logic        cout_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] acc_out,
  output logic        ovf,
  output logic [7:0]  count
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

  logic [0:0]  state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic [24:0] sum_ext;
  logic        xfer;

  assign in_ready = (state_q == ACCUM) && !clear;
  assign xfer     = in_valid && in_ready;
  // Bit 24 of the widened sum is the carry out of bit 23.
  assign sum_ext  = {1'b0, acc_q} + {8'd0, cout_in, sum_in};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else if (state_q == HOLD) begin
      if (out_ready) begin
        state_d = ACCUM;
        acc_d   = '0;
        ovf_d   = 1'b0;
        count_d = '0;
      end
    end else if (xfer) begin
      acc_d   = sum_ext[23:0];
      ovf_d   = ovf_q | sum_ext[24];
      count_d = count_q + 8'd1;
      if (count_q == LAST_IDX) begin
        state_d = HOLD;
      end
    end
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_acc16_stage.sv
// Bench for acc16_stage: two instances (4-beat and 255-beat frames), directed scenarios plus random traffic,
// compared every cycle against an unbounded-integer frame model.
module tb_acc16_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] sum_in    [2];
  logic        cout_in   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        clear     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [23:0] acc_out   [2];
  logic        ovf       [2];
  logic [7:0]  count     [2];

  acc16_stage #(.N_SAMPLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in[0]), .cout_in(cout_in[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .clear(clear[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .acc_out(acc_out[0]),
    .ovf(ovf[0]), .count(count[0])
  );

  acc16_stage #(.N_SAMPLES(255)) u_dut255 (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in[1]), .cout_in(cout_in[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .clear(clear[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .acc_out(acc_out[1]),
    .ovf(ovf[1]), .count(count[1])
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Frame model: the exact running total of accepted beats, the beat count and
  // whether a finished frame is waiting to be taken.
  longint m_total [2];
  int     m_n     [2];
  bit     m_hold  [2];
  int     n_of    [2] = '{4, 255};

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || clear[i] || (m_hold[i] && out_ready[i])) begin
        m_total[i] = 0;
        m_n[i]     = 0;
        m_hold[i]  = 1'b0;
      end else if (!m_hold[i] && in_valid[i]) begin
        m_total[i] = m_total[i] + longint'({cout_in[i], sum_in[i]});
        m_n[i]     = m_n[i] + 1;
        m_hold[i]  = (m_n[i] == n_of[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("out_valid", i, 64'(out_valid[i]), 64'(m_hold[i]));
        chk("acc_out",   i, 64'(acc_out[i]),   64'(m_total[i] % 64'h100_0000));
        chk("ovf",       i, 64'(ovf[i]),       64'(m_total[i] >= 64'h100_0000));
        chk("count",     i, 64'(count[i]),     64'(m_n[i]));
        chk("in_ready",  i, 64'(in_ready[i]),  64'(!m_hold[i] && !clear[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic v, input logic [16:0] b);
    in_valid[i] = v;
    {cout_in[i], sum_in[i]} = b;
  endtask

  logic [16:0] basic_beats [4] = '{17'h0_000F, 17'h0_0010, 17'h0_0005, 17'h1_0000};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(i, 1'b0, 17'h0);
      clear[i]     = 1'b0;
      out_ready[i] = 1'b1;
    end
    #12;
    chk("rst_out_valid", 0, 64'(out_valid[0]), 64'd0);
    chk("rst_acc_out",   1, 64'(acc_out[1]),   64'd0);
    chk("rst_count",     0, 64'(count[0]),     64'd0);
    step();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step();

    // Basic frame.
    for (int k = 0; k < 4; k++) begin
      set_beat(0, 1'b1, basic_beats[k]);
      step();
    end
    set_beat(0, 1'b0, 17'h0);
    chk("basic_valid", 0, 64'(out_valid[0]), 64'd1);
    chk("basic_acc",   0, 64'(acc_out[0]),   64'h01_0024);
    chk("basic_count", 0, 64'(count[0]),     64'd4);
    chk("basic_ovf",   0, 64'(ovf[0]),       64'd0);
    step();
    chk("basic_consumed", 0, 64'(out_valid[0]), 64'd0);

    // Bubbles: beats on even cycles only.
    for (int k = 0; k < 7; k++) begin
      set_beat(0, (k % 2) == 0, basic_beats[k / 2]);
      step();
    end
    set_beat(0, 1'b0, 17'h0);
    chk("bubble_valid", 0, 64'(out_valid[0]), 64'd1);
    chk("bubble_acc",   0, 64'(acc_out[0]),   64'h01_0024);
    step();

    // Backpressure: result held 5 cycles while a beat is offered.
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_beat(0, 1'b1, basic_beats[k]);
      step();
    end
    set_beat(0, 1'b1, 17'h0_0001);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",    0, 64'(out_valid[0]), 64'd1);
      chk("bp_acc",      0, 64'(acc_out[0]),   64'h01_0024);
      chk("bp_in_ready", 0, 64'(in_ready[0]),  64'd0);
      step();
    end
    out_ready[0] = 1'b1;
    set_beat(0, 1'b0, 17'h0);
    step();
    chk("bp_consumed", 0, 64'(out_valid[0]), 64'd0);
    chk("bp_acc_zero", 0, 64'(acc_out[0]),   64'd0);
    set_beat(0, 1'b1, 17'h0_0007);
    step();
    chk("bp_next_acc",   0, 64'(acc_out[0]), 64'd7);
    chk("bp_next_count", 0, 64'(count[0]),   64'd1);
    set_beat(0, 1'b0, 17'h0);
    clear[0] = 1'b1;
    step();
    clear[0] = 1'b0;

    // Clear collides with an offered beat after two accepted beats.
    for (int k = 0; k < 2; k++) begin
      set_beat(0, 1'b1, basic_beats[k]);
      step();
    end
    clear[0] = 1'b1;
    #1;
    chk("clr_in_ready", 0, 64'(in_ready[0]), 64'd0);
    step();
    clear[0] = 1'b0;
    set_beat(0, 1'b0, 17'h0);
    chk("clr_count", 0, 64'(count[0]),   64'd0);
    chk("clr_acc",   0, 64'(acc_out[0]), 64'd0);

    // Asynchronous reset while holding a result.
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_beat(0, 1'b1, basic_beats[k]);
      step();
    end
    set_beat(0, 1'b0, 17'h0);
    chk("ar_pre_valid", 0, 64'(out_valid[0]), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 0, 64'(out_valid[0]), 64'd0);
    chk("ar_acc_out",   0, 64'(acc_out[0]),   64'd0);
    chk("ar_count",     0, 64'(count[0]),     64'd0);
    chk("ar_ovf",       0, 64'(ovf[0]),       64'd0);
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    step();

    // Overflow on the 255-beat instance.
    for (int k = 0; k < 255; k++) begin
      set_beat(1, 1'b1, 17'h1_FFFF);
      step();
    end
    set_beat(1, 1'b0, 17'h0);
    chk("ovf_valid", 1, 64'(out_valid[1]), 64'd1);
    chk("ovf_acc",   1, 64'(acc_out[1]),   64'hFD_FF01);
    chk("ovf_flag",  1, 64'(ovf[1]),       64'd1);
    chk("ovf_count", 1, 64'(count[1]),     64'd255);
    step();

    // Random traffic on both instances.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        set_beat(i, $urandom_range(0, 9) < 7, 17'($urandom));
        clear[i]     = (i == 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 999) == 0);
        out_ready[i] = 1'($urandom_range(0, 1));
      end
      step();
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
